tdc_frame_collector: RTL and testbench

// Single-clock successor to the per-channel TDC sync stage. Gathers one word per enabled channel into a frame.

---
 rtl/tdc_frame_collector_pkg.sv | 24 ++
 rtl/tdc_frame_fifo.sv | 60 ++++++
 rtl/tdc_frame_collector.sv | 150 +++++++++++++++
 tb/tb_tdc_frame_collector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_frame_collector_pkg.sv
// Shared types and sizing for the TDC frame collector.
// The frame layout is what one FIFO entry holds: channel words, hit mask, sequence number.
package tdc_pkg;

   localparam int CH_NUM     = 16;
   localparam int DATA_W     = 10;
   localparam int FIFO_DEPTH = 4;
   localparam int TMO_W      = 16;
   localparam int SEQ_W      = 8;
   localparam int OVF_W      = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_COMMIT  = 2'd2
   } fsm_t;

   typedef struct packed {
      logic [CH_NUM*DATA_W-1:0] data;
      logic [CH_NUM-1:0]        hit;
      logic [SEQ_W-1:0]         seq;
   } frame_t;

endpackage

// File: rtl/tdc_frame_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is taken only when a pop happens in the same cycle.
// The head word is presented as zero while the FIFO is empty.
module tdc_frame_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty     = (level_r == LW'(0));
   assign full      = (level_r == LW'(DEPTH));
   assign pop_ok_s  = pop & ~empty;
   assign push_ok_s = push & (~full | pop_ok_s);
   assign dout      = empty ? WIDTH'(0) : mem_r[rd_ptr_r];
   assign level     = level_r;

   // Storage array; never read while empty, so it needs no reset
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Read/write pointers and occupancy
   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         level_r  <= LW'(0);
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/tdc_frame_collector.sv
// Gathers one word per masked TDC channel into a frame and commits it to a frame FIFO.
// Frames close when every masked channel has hit, or on timeout in partial mode.
module tdc_frame_collector
   import tdc_pkg::*;
(
   input  logic                          clock,
   input  logic                          rst,
   input  logic [CH_NUM*DATA_W-1:0]      ch_data,
   input  logic [CH_NUM-1:0]             ch_wr,
   input  logic [CH_NUM-1:0]             ch_mask,
   input  logic                          mode,
   input  logic [TMO_W-1:0]              timeout,
   output logic [CH_NUM*DATA_W-1:0]      out_data,
   output logic [CH_NUM-1:0]             out_hit,
   output logic [SEQ_W-1:0]              out_seq,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [OVF_W-1:0]              ovf_cnt,
   output logic                          busy
);
   localparam int FRAME_W = $bits(frame_t);

   fsm_t                     state_r;
   fsm_t                     state_nxt_s;
   logic [CH_NUM*DATA_W-1:0] data_r;
   logic [CH_NUM-1:0]        hit_r;
   logic [CH_NUM-1:0]        accepted_s;
   logic [TMO_W-1:0]         tmr_r;
   logic [TMO_W-1:0]         tmr_nxt_s;
   logic [TMO_W-1:0]         tmo_eff_s;
   logic [SEQ_W-1:0]         seq_r;
   logic [OVF_W-1:0]         ovf_r;
   logic                     gathering_s;
   logic                     complete_s;
   logic                     commit_s;
   logic                     pop_s;
   logic                     push_ok_s;
   logic                     fifo_full_s;
   logic                     fifo_empty_s;
   frame_t                   frame_in_s;
   frame_t                   frame_out_s;

   // Repeat writes to an already-hit channel are filtered here, so the first write wins
   assign gathering_s = (state_r == S_IDLE) || (state_r == S_COLLECT);
   assign accepted_s  = gathering_s ? (ch_wr & ch_mask & ~hit_r) : CH_NUM'(0);
   assign complete_s  = (((hit_r | accepted_s) & ch_mask) == ch_mask);
   assign tmo_eff_s   = (timeout == TMO_W'(0)) ? TMO_W'(1) : timeout;
   assign pop_s       = ~fifo_empty_s & out_ready;
   assign push_ok_s   = commit_s & (~fifo_full_s | pop_s);

   // Next-state and timeout counter logic
   always_comb begin
      state_nxt_s = state_r;
      tmr_nxt_s   = tmr_r;
      commit_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (|accepted_s) begin
               tmr_nxt_s   = TMO_W'(1);
               state_nxt_s = complete_s ? S_COMMIT : S_COLLECT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_COLLECT: begin
            if (complete_s) begin
               state_nxt_s = S_COMMIT;
            end else if (mode && (tmr_r >= tmo_eff_s)) begin
               state_nxt_s = S_COMMIT;
            end else begin
               state_nxt_s = S_COLLECT;
               tmr_nxt_s   = (tmr_r != '1) ? (tmr_r + TMO_W'(1)) : tmr_r;
            end
         end
         S_COMMIT: begin
            commit_s    = 1'b1;
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // FSM state and timeout counter registers
   always_ff @(posedge clock) begin
      if (rst) begin
         state_r <= S_IDLE;
         tmr_r   <= TMO_W'(0);
      end else begin
         state_r <= state_nxt_s;
         tmr_r   <= tmr_nxt_s;
      end
   end

   // Capture registers plus sequence and drop counters
   always_ff @(posedge clock) begin
      if (rst) begin
         data_r <= '0;
         hit_r  <= CH_NUM'(0);
         seq_r  <= SEQ_W'(0);
         ovf_r  <= OVF_W'(0);
      end else if (commit_s) begin
         data_r <= '0;
         hit_r  <= CH_NUM'(0);
         if (push_ok_s) begin
            seq_r <= seq_r + SEQ_W'(1);
         end else if (ovf_r != '1) begin
            ovf_r <= ovf_r + OVF_W'(1);
         end else begin
            ovf_r <= ovf_r;
         end
      end else begin
         hit_r <= hit_r | accepted_s;
         for (int i = 0; i < CH_NUM; i++) begin
            if (accepted_s[i]) begin
               data_r[i*DATA_W +: DATA_W] <= ch_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign frame_in_s.data = data_r;
   assign frame_in_s.hit  = hit_r;
   assign frame_in_s.seq  = seq_r;

   tdc_frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .rst   (rst),
      .push  (commit_s),
      .din   (frame_in_s),
      .pop   (pop_s),
      .dout  (frame_out_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level)
   );

   assign out_data  = frame_out_s.data;
   assign out_hit   = frame_out_s.hit;
   assign out_seq   = frame_out_s.seq;
   assign out_valid = ~fifo_empty_s;
   assign ovf_cnt   = ovf_r;
   assign busy      = (state_r != S_IDLE);

endmodule

// File: tb/tb_tdc_frame_collector.sv
// Scoreboard bench for tdc_frame_collector: a cycle-counting reference model queues expected frames,
// a monitor pops and compares them whenever the DUT hands a frame over.
`timescale 1ns/1ps
module tb_tdc_frame_collector;
   import tdc_pkg::*;

   localparam int DW_ALL = CH_NUM*DATA_W;

   logic                        clock = 1'b0;
   logic                        rst = 1'b1;
   logic [DW_ALL-1:0]           ch_data = '0;
   logic [CH_NUM-1:0]           ch_wr = '0;
   logic [CH_NUM-1:0]           ch_mask = '0;
   logic                        mode = 1'b0;
   logic [TMO_W-1:0]            timeout = '0;
   logic [DW_ALL-1:0]           out_data;
   logic [CH_NUM-1:0]           out_hit;
   logic [SEQ_W-1:0]            out_seq;
   logic                        out_valid;
   logic                        out_ready = 1'b0;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
   logic [7:0]                  ovf_cnt;
   logic                        busy;

   tdc_frame_collector dut (
      .clock(clock), .rst(rst), .ch_data(ch_data), .ch_wr(ch_wr), .ch_mask(ch_mask),
      .mode(mode), .timeout(timeout), .out_data(out_data), .out_hit(out_hit), .out_seq(out_seq),
      .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
      .ovf_cnt(ovf_cnt), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [DW_ALL-1:0] data;
      logic [CH_NUM-1:0] hit;
      int                seq;
   } exp_frame_t;

   exp_frame_t exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame contents as per-channel words, closure decided from cycle counts
   bit m_init = 0, m_open = 0, m_commit = 0;
   int m_word[CH_NUM];
   logic [CH_NUM-1:0] m_hit = '0;
   int m_first = 0, cyc = 0, m_level = 0, m_ovf = 0, m_seq = 0;

   always @(negedge clock) begin
      bit pop;
      int tmo;
      logic [CH_NUM-1:0] acc;
      exp_frame_t f;
      if (m_init) begin
         check("fifo_level", fifo_level, m_level);
         check("ovf_cnt", ovf_cnt, m_ovf);
         check("out_valid", out_valid, m_level > 0);
         check("busy", busy, m_open || m_commit);
      end
      if (rst) begin
         m_init = 1; m_open = 0; m_commit = 0; m_hit = '0;
         m_level = 0; m_ovf = 0; m_seq = 0;
         for (int i = 0; i < CH_NUM; i++) m_word[i] = 0;
         exp_q.delete();
      end else begin
         pop = (m_level > 0) && out_ready;
         if (m_commit) begin
            if (m_level < FIFO_DEPTH || pop) begin
               for (int i = 0; i < CH_NUM; i++) f.data[i*DATA_W +: DATA_W] = m_word[i][DATA_W-1:0];
               f.hit = m_hit;
               f.seq = m_seq;
               exp_q.push_back(f);
               m_seq = (m_seq + 1) % 256;
               m_level++;
            end else if (m_ovf < 255) begin
               m_ovf++;
            end
            m_commit = 0;
            m_hit = '0;
            for (int i = 0; i < CH_NUM; i++) m_word[i] = 0;
         end else begin
            acc = ch_wr & ch_mask & ~m_hit;
            for (int i = 0; i < CH_NUM; i++) if (acc[i]) m_word[i] = int'(ch_data[i*DATA_W +: DATA_W]);
            m_hit = m_hit | acc;
            if (!m_open) begin
               if (acc != '0) begin
                  m_first = cyc;
                  if ((m_hit & ch_mask) == ch_mask) m_commit = 1;
                  else m_open = 1;
               end
            end else begin
               tmo = (timeout == 0) ? 1 : int'(timeout);
               if ((m_hit & ch_mask) == ch_mask || (mode && (cyc - m_first) >= tmo)) begin
                  m_open = 0;
                  m_commit = 1;
               end
            end
         end
         if (pop) m_level--;
      end
      cyc++;
   end

   // Monitor: every handed-over frame must match the oldest expected one
   always @(negedge clock) begin
      exp_frame_t e;
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: DUT delivered seq %0d, hit %0h with nothing expected", out_seq, out_hit);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", out_data, e.data);
            check("sb_hit", out_hit, e.hit);
            check("sb_seq", out_seq, e.seq[SEQ_W-1:0]);
         end
      end
   end

   initial begin
      #300us;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      ch_wr = '0;
      repeat (n) tick();
   endtask

   task automatic wr(input int ch, input int d);
      ch_wr = '0;
      ch_wr[ch] = 1'b1;
      ch_data[ch*DATA_W +: DATA_W] = d[DATA_W-1:0];
      tick();
      ch_wr = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ch_wr = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic pair_frame();
      ch_wr = 16'h0003;
      tick();
      ch_wr = '0;
      tick();
   endtask

   initial begin
      do_reset();
      check("rst_valid", out_valid, 1'b0);
      check("rst_level", fifo_level, 0);
      check("rst_data", out_data, 0);

      // 1: full frame in wait-all mode
      ch_mask = 16'h000F; mode = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(i, i + 1);
      check("t1_valid_edge1", out_valid, 1'b0);
      tick();
      check("t1_valid_edge2", out_valid, 1'b1);
      check("t1_hit", out_hit, 16'h000F);
      check("t1_word3", out_data[3*DATA_W +: DATA_W], 10'd4);
      out_ready = 1'b1;
      idle(3);

      // 2: partial frame on timeout, then the same stimulus without timeout
      do_reset();
      ch_mask = 16'h0003; mode = 1'b1; timeout = 16'd5; out_ready = 1'b0;
      wr(0, 10'h12);
      idle(5);
      check("t2_not_yet", out_valid, 1'b0);
      idle(1);
      check("t2_partial_valid", out_valid, 1'b1);
      check("t2_partial_hit", out_hit, 16'h0001);
      out_ready = 1'b1;
      idle(3);
      do_reset();
      mode = 1'b0;
      wr(0, 10'h12);
      idle(100);
      check("t2_mode0_valid", out_valid, 1'b0);
      check("t2_mode0_busy", busy, 1'b1);

      // 3: first write wins
      do_reset();
      out_ready = 1'b0;
      wr(0, 10'h155);
      wr(0, 10'h0AA);
      wr(1, 10'h3FF);
      idle(2);
      check("t3_ch0", out_data[DATA_W-1:0], 10'h155);
      out_ready = 1'b1;
      idle(2);

      // 4: overflow with consumer stalled, then in-order drain
      do_reset();
      out_ready = 1'b0;
      repeat (6) pair_frame();
      check("t4_level", fifo_level, 4);
      check("t4_ovf", ovf_cnt, 2);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t4_drain_seq", out_seq, k);
         tick();
      end
      check("t4_empty", out_valid, 1'b0);

      // 5: commit into a full FIFO while it is being popped
      out_ready = 1'b0;
      repeat (4) pair_frame();
      ch_wr = 16'h0003;
      tick();
      ch_wr = '0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t5_level", fifo_level, 4);
      check("t5_ovf", ovf_cnt, 2);
      check("t5_head_seq", out_seq, 5);
      out_ready = 1'b1;
      idle(6);

      // 6: reset in the middle of a frame
      do_reset();
      ch_mask = 16'h000F; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(i, 10'h30 + i);
      idle(1);
      wr(0, 10'h1); wr(1, 10'h2);
      check("t6_busy_before", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_valid", out_valid, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_level", fifo_level, 0);
      check("t6_hit", out_hit, 0);
      check("t6_seq", out_seq, 0);
      ch_mask = 16'h0003;
      pair_frame();
      check("t6_new_seq", out_seq, 0);
      check("t6_new_hit", out_hit, 16'h0003);
      out_ready = 1'b1;
      idle(2);

      // Randomized traffic with live mask/mode/timeout changes
      do_reset();
      for (int c = 0; c < 1200; c++) begin
         if (c % 64 == 0) begin
            ch_mask = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom & 32'h0000_00FF);
            mode = 1'($urandom_range(0, 1));
            timeout = 16'($urandom_range(0, 8));
         end
         ch_wr = 16'($urandom & $urandom & $urandom);
         for (int i = 0; i < CH_NUM; i++) ch_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      ch_wr = '0; mode = 1'b1; timeout = 16'd1; out_ready = 1'b1;
      idle(40);
      check("sb_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
